mem_copy_engine: RTL and testbench

//  Block copy/fill sequencer sitting directly upstream of the 256x8 data memory.

---
 rtl/mem_copy_engine.sv | 132 +++++++++++++
 tb/tb_mem_copy_engine.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_copy_engine.sv
// Block copy/fill sequencer in front of a single-port data memory.
// Shares the memory port with the CPU and stalls the CPU while a transfer runs.
module mem_copy_engine #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk_i,
  input  logic          reset_ni,
  input  logic          start_i,
  input  logic          mode_i,
  input  logic [AW-1:0] src_addr_i,
  input  logic [AW-1:0] dst_addr_i,
  input  logic [AW-1:0] len_i,
  input  logic [DW-1:0] fill_val_i,
  input  logic          abort_i,
  input  logic [AW-1:0] cpu_addr_i,
  input  logic [DW-1:0] cpu_data_in_i,
  input  logic          cpu_write_en_i,
  input  logic [DW-1:0] mem_data_out_i,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_data_in_o,
  output logic          mem_write_en_o,
  output logic [DW-1:0] cpu_data_out_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          cpu_stall_o
);

  typedef enum logic [1:0] {IDLE, RD, WR, FIN} state_t;

  state_t        state_q, state_d;
  logic          mode_q, mode_d;
  logic [AW-1:0] src_q, src_d;
  logic [AW-1:0] dst_q, dst_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] hold_q, hold_d;
  logic [DW-1:0] fill_q, fill_d;
  logic          accept;

  assign accept = ((state_q == IDLE) || (state_q == FIN)) && start_i;

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      hold_q  <= '0;
      fill_q  <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      fill_q  <= fill_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, FIN: begin
        if (start_i) begin
          if (len_i == '0)  state_d = FIN;
          else if (mode_i)  state_d = WR;
          else              state_d = RD;
        end else begin
          state_d = IDLE;
        end
      end
      RD: state_d = abort_i ? IDLE : WR;
      WR: begin
        if (abort_i)              state_d = IDLE;
        else if (cnt_q == AW'(1)) state_d = FIN;
        else if (mode_q)          state_d = WR;
        else                      state_d = RD;
      end
      default: state_d = IDLE;
    endcase
  end

  // Address counters wrap naturally at AW bits.
  always_comb begin
    mode_d = mode_q;
    src_d  = src_q;
    dst_d  = dst_q;
    cnt_d  = cnt_q;
    hold_d = hold_q;
    fill_d = fill_q;
    if (accept) begin
      mode_d = mode_i;
      src_d  = src_addr_i;
      dst_d  = dst_addr_i;
      cnt_d  = len_i;
      fill_d = fill_val_i;
    end else if (state_q == RD) begin
      hold_d = mem_data_out_i;
      src_d  = src_q + AW'(1);
    end else if (state_q == WR) begin
      dst_d  = dst_q + AW'(1);
      cnt_d  = cnt_q - AW'(1);
    end
  end

  always_comb begin
    busy_o         = (state_q == RD) || (state_q == WR);
    done_o         = (state_q == FIN);
    cpu_stall_o    = busy_o;
    cpu_data_out_o = mem_data_out_i;
    mem_addr_o     = cpu_addr_i;
    mem_data_in_o  = cpu_data_in_i;
    mem_write_en_o = cpu_write_en_i;
    unique case (state_q)
      RD: begin
        mem_addr_o     = src_q;
        mem_data_in_o  = hold_q;
        mem_write_en_o = 1'b0;
      end
      WR: begin
        mem_addr_o     = dst_q;
        mem_data_in_o  = mode_q ? fill_q : hold_q;
        // Abort and an asserted reset both suppress the in-flight engine write.
        mem_write_en_o = !abort_i && reset_ni;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Bench for mem_copy_engine: behavioural 256x8 memory, reference memory image,
// and a queue of expected engine writes checked as the engine issues them.
module tb_mem_copy_engine;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, mode, abort, cpu_we;
  logic [7:0] src, dst, len, fill, cpu_addr, cpu_din;
  logic [7:0] mem_dout, mem_addr, mem_din, cpu_dout;
  logic       mem_we, busy, done, stall;

  logic [7:0]  mem [256] = '{default: 8'h00};
  logic [7:0]  ref_mem [256] = '{default: 8'h00};
  logic [15:0] sb_q [$];
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  mem_copy_engine #(.AW(8), .DW(8)) dut (
    .clk_i(clk), .reset_ni(rst_n), .start_i(start), .mode_i(mode),
    .src_addr_i(src), .dst_addr_i(dst), .len_i(len), .fill_val_i(fill),
    .abort_i(abort), .cpu_addr_i(cpu_addr), .cpu_data_in_i(cpu_din),
    .cpu_write_en_i(cpu_we), .mem_data_out_i(mem_dout), .mem_addr_o(mem_addr),
    .mem_data_in_o(mem_din), .mem_write_en_o(mem_we), .cpu_data_out_o(cpu_dout),
    .busy_o(busy), .done_o(done), .cpu_stall_o(stall)
  );

  assign mem_dout = mem[mem_addr];
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_din;

  task automatic chk(input string tag, input int unsigned act, input int unsigned exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Engine write monitor: every write while busy must match the next queued one.
  always begin
    logic [15:0] e;
    @(negedge clk); #1;
    if (busy && mem_we) begin
      if (sb_q.size() == 0) chk("wr_unexpected", 1, 0);
      else begin
        e = sb_q.pop_front();
        chk("wr_addr", mem_addr, e[15:8]);
        chk("wr_data", mem_din, e[7:0]);
      end
    end
  end

  task automatic cpu_wr(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    cpu_addr = a; cpu_din = d; cpu_we = 1'b1;
    @(posedge clk); #1;
    cpu_we = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic mem_cmp(input string tag);
    int bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
    chk(tag, bad, 0);
  endtask

  task automatic post(input string tag);
    @(negedge clk);
    chk({tag, "_done_after"}, done, 0);
    chk({tag, "_busy_after"}, busy, 0);
  endtask

  // cut: bytes expected to land; abort_at/rst_at/start_at: cycle index after accept (0 = unused).
  task automatic launch(input logic m, input logic [7:0] s, input logic [7:0] d,
                        input logic [7:0] n, input logic [7:0] f, input int cut,
                        input int abort_at, input int rst_at, input int start_at,
                        output int done_cyc, output int busy_cyc);
    logic [7:0] a, v;
    bit fin = 0;
    for (int i = 0; i < cut; i++) begin
      a = d + 8'(i);
      v = m ? f : ref_mem[8'(s + 8'(i))];
      ref_mem[a] = v;
      sb_q.push_back({a, v});
    end
    done_cyc = 0; busy_cyc = 0;
    @(negedge clk);
    mode = m; src = s; dst = d; len = n; fill = f; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 1; cyc <= 600; cyc++) begin
      @(negedge clk);
      if (cyc == abort_at + 1) abort = 1'b0;
      if (cyc == rst_at + 1)   rst_n = 1'b1;
      if (cyc == start_at + 1) start = 1'b0;
      if (cyc == abort_at) abort = 1'b1;
      if (cyc == rst_at)   rst_n = 1'b0;
      if (cyc == start_at) begin
        start = 1'b1; mode = ~m; src = s + 8'd50; dst = d + 8'd50; len = 8'd3;
      end
      if (busy) busy_cyc++;
      else begin
        done_cyc = done ? cyc : 0;
        chk("stall_low_at_end", stall, 0);
        fin = 1;
        break;
      end
    end
    if (!fin) chk("timeout", 1, 0);
    chk("sb_drained", sb_q.size(), 0);
  endtask

  initial begin
    int dc, bc, extra_done, extra_busy;
    rst_n = 1'b0; start = 0; mode = 0; abort = 0; cpu_we = 0;
    src = 0; dst = 0; len = 0; fill = 0; cpu_addr = 0; cpu_din = 0;

    // Reset state and CPU ownership of the port
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_stall", stall, 0);
    cpu_addr = 8'd100; cpu_din = 8'h5A; cpu_we = 1'b1; #1;
    chk("rst_we_pass", mem_we, 1);
    chk("rst_addr_pass", mem_addr, 100);
    chk("rst_data_pass", mem_din, 8'h5A);
    @(posedge clk); #1; cpu_we = 1'b0; ref_mem[100] = 8'h5A;
    @(negedge clk); rst_n = 1'b1;

    // T1 copy
    for (int i = 0; i < 4; i++) cpu_wr(8'(16 + i), 8'(i + 1));
    launch(0, 8'd16, 8'd200, 8'd4, 8'h00, 4, 0, 0, 0, dc, bc);
    chk("t1_done_cyc", dc, 9);
    chk("t1_busy_cyc", bc, 8);
    for (int i = 0; i < 4; i++) chk("t1_mem", mem[200 + i], i + 1);
    post("t1");
    mem_cmp("t1_image");

    // T2 fill with wrap
    cpu_wr(8'd2, 8'h77);
    launch(1, 8'd0, 8'd254, 8'd4, 8'hA5, 4, 0, 0, 0, dc, bc);
    chk("t2_done_cyc", dc, 5);
    chk("t2_busy_cyc", bc, 4);
    chk("t2_mem254", mem[254], 8'hA5);
    chk("t2_mem255", mem[255], 8'hA5);
    chk("t2_mem0", mem[0], 8'hA5);
    chk("t2_mem1", mem[1], 8'hA5);
    chk("t2_mem2", mem[2], 8'h77);
    post("t2");
    mem_cmp("t2_image");

    // T3 overlapping copy replicates the source byte
    cpu_wr(8'd10, 8'd7);
    for (int i = 11; i < 14; i++) cpu_wr(8'(i), 8'd0);
    launch(0, 8'd10, 8'd11, 8'd3, 8'h00, 3, 0, 0, 0, dc, bc);
    chk("t3_done_cyc", dc, 7);
    for (int i = 11; i < 14; i++) chk("t3_mem", mem[i], 7);
    post("t3");
    mem_cmp("t3_image");

    // T4 zero length, then Start while busy
    launch(0, 8'd5, 8'd6, 8'd0, 8'h00, 0, 0, 0, 0, dc, bc);
    chk("t4_len0_done", dc, 1);
    chk("t4_len0_busy", bc, 0);
    post("t4a");
    launch(0, 8'd16, 8'd100, 8'd4, 8'h00, 4, 0, 0, 3, dc, bc);
    chk("t4_mid_done", dc, 9);
    chk("t4_mid_busy", bc, 8);
    extra_done = 0; extra_busy = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) extra_done++;
      if (busy) extra_busy++;
    end
    chk("t4_no_second_done", extra_done, 0);
    chk("t4_no_second_busy", extra_busy, 0);
    mem_cmp("t4_image");

    // T5 abort and reset during the third write of a fill
    launch(1, 8'd0, 8'd60, 8'd8, 8'hC3, 2, 3, 0, 0, dc, bc);
    chk("t5_abort_done", dc, 0);
    chk("t5_abort_busy", bc, 3);
    chk("t5_abort_mem62", mem[62], 0);
    post("t5a");
    mem_cmp("t5a_image");
    launch(1, 8'd0, 8'd70, 8'd8, 8'hC3, 2, 0, 3, 0, dc, bc);
    chk("t5_rst_done", dc, 0);
    chk("t5_rst_busy", bc, 3);
    chk("t5_rst_mem71", mem[71], 8'hC3);
    chk("t5_rst_mem72", mem[72], 0);
    post("t5b");
    mem_cmp("t5b_image");

    // T6 CPU port mux
    cpu_wr(8'd40, 8'h3C);
    chk("t6_idle_store", mem[40], 8'h3C);
    @(negedge clk);
    cpu_addr = 8'd40; cpu_din = 8'h3C; cpu_we = 1'b1;
    launch(1, 8'd0, 8'd40, 8'd1, 8'h11, 1, 0, 0, 0, dc, bc);
    chk("t6_done_cyc", dc, 2);
    chk("t6_fill_wins", mem[40], 8'h11);
    @(negedge clk);
    cpu_we = 1'b0;
    ref_mem[40] = 8'h3C;
    chk("t6_done_after", done, 0);
    chk("t6_cpu_after", mem[40], 8'h3C);
    mem_cmp("t6_image");

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
